// File: rtl/gpio_in_port_pkg.sv
// rtl/gpio_in_port_pkg.sv - shared GPIO address map, register offsets and bit indices
package gpio_in_port_pkg;

    localparam logic [31:0] GPIO_OUT_BASE = 32'h8000_0000;
    localparam logic [31:0] GPIO_IN_BASE  = 32'h8000_0010;

    localparam logic [31:0] OFF_DATA   = 32'd0;
    localparam logic [31:0] OFF_STATUS = 32'd4;
    localparam logic [31:0] OFF_CTRL   = 32'd8;

    localparam int BIT_RISE = 0;
    localparam int BIT_FALL = 1;

    // One-cycle accept event from the debouncer and the level it moved to.
    typedef struct packed {
        logic valid;
        logic rise;
    } gpio_edge_t;

endpackage

// File: rtl/gpio_debounce.sv
// rtl/gpio_debounce.sv - pin synchroniser and debouncer; GPIO_IN_DEBOUNCE_EN enables the hold counter
module gpio_debounce
    import gpio_in_port_pkg::*;
`ifdef GPIO_IN_DEBOUNCE_EN
#(
    parameter int DEBOUNCE_CYCLES = 4
)
`endif
(
    input  logic       i_clk,
    input  logic       i_resetn,
    input  logic       i_pin,
    output logic       o_stable,
    output gpio_edge_t o_edge
);

    logic r_sync1;
    logic r_sync2;
    logic r_stable;
    logic w_accept;

    always_ff @(posedge i_clk) begin
        if (!i_resetn) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_pin;
            r_sync2 <= r_sync1;
        end
    end

`ifdef GPIO_IN_DEBOUNCE_EN
    localparam logic [7:0] LP_CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);

    logic [7:0] r_cnt;

    // A new level must be seen DEBOUNCE_CYCLES times in a row; any return to the old level restarts the count.
    assign w_accept = (r_sync2 != r_stable) && (r_cnt == LP_CNT_LAST);

    always_ff @(posedge i_clk) begin
        if (!i_resetn) begin
            r_cnt <= 8'd0;
        end else if (r_sync2 == r_stable) begin
            r_cnt <= 8'd0;
        end else if (r_cnt == LP_CNT_LAST) begin
            r_cnt <= 8'd0;
        end else begin
            r_cnt <= r_cnt + 8'd1;
        end
    end
`else
    assign w_accept = (r_sync2 != r_stable);
`endif

    always_ff @(posedge i_clk) begin
        if (!i_resetn) begin
            r_stable <= 1'b0;
        end else if (w_accept) begin
            r_stable <= r_sync2;
        end
    end

    assign o_stable     = r_stable;
    assign o_edge.valid = w_accept;
    assign o_edge.rise  = r_sync2;

endmodule

// File: rtl/gpio_in_port.sv
// rtl/gpio_in_port.sv - memory-mapped debounced GPIO input with sticky edge flags and irq (GPIO_IN_DEBOUNCE_EN)
module gpio_in_port
    import gpio_in_port_pkg::*;
#(
    parameter logic [31:0] GPIO_IN_ADDR = GPIO_IN_BASE
`ifdef GPIO_IN_DEBOUNCE_EN
    ,
    parameter int DEBOUNCE_CYCLES = 4
`endif
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic        WE,
    input  logic [31:0] A,
    input  logic [31:0] WD,
    output logic [31:0] RD,
    input  logic        gpio_in_pin,
    output logic        irq
);

    logic        w_stable;
    gpio_edge_t  w_edge;

    logic [1:0]  r_status;
    logic [1:0]  r_ctrl;
    logic [31:0] r_rd;

    logic        w_sel_data;
    logic        w_sel_status;
    logic        w_sel_ctrl;
    logic [1:0]  w_clr;
    logic [1:0]  w_set;
    logic [1:0]  w_status_next;
    logic [31:0] w_rd_next;
    logic        w_unused_wd;

    gpio_debounce
`ifdef GPIO_IN_DEBOUNCE_EN
    #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    )
`endif
    u_debounce (
        .i_clk    (CLK),
        .i_resetn (reset),
        .i_pin    (gpio_in_pin),
        .o_stable (w_stable),
        .o_edge   (w_edge)
    );

    assign w_sel_data   = (A == GPIO_IN_ADDR + OFF_DATA);
    assign w_sel_status = (A == GPIO_IN_ADDR + OFF_STATUS);
    assign w_sel_ctrl   = (A == GPIO_IN_ADDR + OFF_CTRL);

    assign w_unused_wd  = ^WD[31:2];

    // Set is OR'd in after the clear so a coincident edge survives its own W1C.
    always_comb begin
        w_clr = 2'b00;
        w_set = 2'b00;
        if (WE && w_sel_status) begin
            w_clr = WD[1:0];
        end
        if (w_edge.valid) begin
            w_set[BIT_RISE] = w_edge.rise;
            w_set[BIT_FALL] = ~w_edge.rise;
        end
        w_status_next = (r_status & ~w_clr) | w_set;
    end

    always_comb begin
        w_rd_next = 32'd0;
        if (w_sel_data) begin
            w_rd_next = {31'd0, w_stable};
        end else if (w_sel_status) begin
            w_rd_next = {30'd0, r_status};
        end else if (w_sel_ctrl) begin
            w_rd_next = {30'd0, r_ctrl};
        end
    end

    always_ff @(posedge CLK) begin
        if (!reset) begin
            r_status <= 2'b00;
            r_ctrl   <= 2'b00;
            r_rd     <= 32'd0;
        end else begin
            r_status <= w_status_next;
            r_rd     <= w_rd_next;
            if (WE && w_sel_ctrl) begin
                r_ctrl <= WD[1:0];
            end
        end
    end

    assign RD  = r_rd;
    assign irq = (r_status[BIT_RISE] & r_ctrl[BIT_RISE]) |
                 (r_status[BIT_FALL] & r_ctrl[BIT_FALL]);

endmodule
